// File: rtl/sdes_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : sdes_decrypt (with helper sdes_s0)
// Purpose  : Multi-cycle S-DES decryption engine. A request latches a 10-bit
//            key and an 8-bit ciphertext, derives K1/K2, runs the two Feistel
//            rounds (K2 first) and presents the registered plaintext with a
//            one-cycle done pulse four clocks after the request.
// Revision : 1.0  initial release
// ============================================================================

// ----------------------------------------------------------------------------
// sdes_s0 : S-DES substitution box S0. Row = nibble bits 1,4; column = 2,3
// (MSB-first numbering, so bit 1 is nib_i[3]).
// ----------------------------------------------------------------------------
module sdes_s0 (
  input  logic [3:0] nib_i,
  output logic [1:0] val_o
);

  logic [1:0] row;
  logic [1:0] col;

  // Table lookup addressed by {row, col}.
  always_comb begin
    row   = {nib_i[3], nib_i[0]};
    col   = {nib_i[2], nib_i[1]};
    val_o = 2'd0;
    case ({row, col})
      4'h0: val_o = 2'd1;
      4'h1: val_o = 2'd0;
      4'h2: val_o = 2'd3;
      4'h3: val_o = 2'd2;
      4'h4: val_o = 2'd3;
      4'h5: val_o = 2'd2;
      4'h6: val_o = 2'd1;
      4'h7: val_o = 2'd0;
      4'h8: val_o = 2'd0;
      4'h9: val_o = 2'd2;
      4'hA: val_o = 2'd1;
      4'hB: val_o = 2'd3;
      4'hC: val_o = 2'd3;
      4'hD: val_o = 2'd1;
      4'hE: val_o = 2'd3;
      4'hF: val_o = 2'd2;
      default: val_o = 2'd0;
    endcase
  end

endmodule

// ----------------------------------------------------------------------------
// sdes_decrypt : top level
// ----------------------------------------------------------------------------
module sdes_decrypt (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [9:0] key,
  input  logic [7:0] ct_in,
  output logic [7:0] pt_out,
  output logic       busy,
  output logic       done
);

  // --------------------------------------------------------------------------
  // Bit-level permutations. S-DES numbers bits 1..N from the MSB, so
  // position p of an N-bit vector is index N-p.
  // --------------------------------------------------------------------------
  function automatic logic [9:0] perm_p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  // P8 selects 8 of the 10 shifted key bits; bits 1 and 2 are discarded.
  function automatic logic [7:0] perm_p8(input logic [9:0] k);
    return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
  endfunction

  function automatic logic [7:0] perm_ip(input logic [7:0] x);
    return {x[6], x[2], x[5], x[7], x[4], x[0], x[3], x[1]};
  endfunction

  function automatic logic [7:0] perm_ip_inv(input logic [7:0] x);
    return {x[4], x[7], x[5], x[3], x[1], x[6], x[0], x[2]};
  endfunction

  function automatic logic [7:0] perm_ep(input logic [3:0] r);
    return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
  endfunction

  function automatic logic [3:0] perm_p4(input logic [3:0] s);
    return {s[2], s[0], s[1], s[3]};
  endfunction

  function automatic logic [4:0] rot_l1(input logic [4:0] h);
    return {h[3:0], h[4]};
  endfunction

  function automatic logic [4:0] rot_l2(input logic [4:0] h);
    return {h[2:0], h[4:3]};
  endfunction

  // S1 substitution box, same row/column addressing as S0.
  function automatic logic [1:0] sbox_s1(input logic [3:0] n);
    logic [1:0] v;
    v = 2'd0;
    case ({n[3], n[0], n[2], n[1]})
      4'h0: v = 2'd0;
      4'h1: v = 2'd1;
      4'h2: v = 2'd2;
      4'h3: v = 2'd3;
      4'h4: v = 2'd2;
      4'h5: v = 2'd0;
      4'h6: v = 2'd1;
      4'h7: v = 2'd3;
      4'h8: v = 2'd3;
      4'h9: v = 2'd0;
      4'hA: v = 2'd1;
      4'hB: v = 2'd0;
      4'hC: v = 2'd2;
      4'hD: v = 2'd1;
      4'hE: v = 2'd0;
      4'hF: v = 2'd3;
      default: v = 2'd0;
    endcase
    return v;
  endfunction

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    KEYGEN = 3'd1,
    ROUND1 = 3'd2,
    ROUND2 = 3'd3,
    FINAL  = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] key_q,   key_d;
  logic [7:0] ct_q,    ct_d;
  logic [7:0] k1_q,    k1_d;
  logic [7:0] k2_q,    k2_d;
  logic [7:0] data_q,  data_d;
  logic [7:0] pt_q,    pt_d;
  logic       done_q,  done_d;

  // FSM-issued step strobes
  logic latch_in;
  logic gen_keys;
  logic do_round1;
  logic do_round2;
  logic do_final;

  // --------------------------------------------------------------------------
  // Key schedule, evaluated from the latched key during KEYGEN.
  // --------------------------------------------------------------------------
  logic [9:0] p10_key;
  logic [4:0] ls1_left;
  logic [4:0] ls1_right;
  logic [7:0] k1_sched;
  logic [7:0] k2_sched;

  assign p10_key   = perm_p10(key_q);
  assign ls1_left  = rot_l1(p10_key[9:5]);
  assign ls1_right = rot_l1(p10_key[4:0]);
  assign k1_sched  = perm_p8({ls1_left, ls1_right});
  assign k2_sched  = perm_p8({rot_l2(ls1_left), rot_l2(ls1_right)});

  // --------------------------------------------------------------------------
  // Single shared fk round. ROUND1 uses K2 (decryption reverses key order),
  // ROUND2 uses K1.
  // --------------------------------------------------------------------------
  logic [7:0] round_key;
  logic [7:0] ep_mix;
  logic [1:0] s0_val;
  logic [1:0] s1_val;
  logic [3:0] f_out;
  logic [7:0] fk_out;

  assign round_key = (state_q == ROUND1) ? k2_q : k1_q;
  assign ep_mix    = perm_ep(data_q[3:0]) ^ round_key;

  sdes_s0 u_s0 (
    .nib_i (ep_mix[7:4]),
    .val_o (s0_val)
  );

  assign s1_val = sbox_s1(ep_mix[3:0]);
  assign f_out  = perm_p4({s0_val, s1_val});
  assign fk_out = {data_q[7:4] ^ f_out, data_q[3:0]};

  // State register; reset returns to IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and per-state step strobes.
  always_comb begin
    state_d   = state_q;
    latch_in  = 1'b0;
    gen_keys  = 1'b0;
    do_round1 = 1'b0;
    do_round2 = 1'b0;
    do_final  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          latch_in = 1'b1;
          state_d  = KEYGEN;
        end
      end
      KEYGEN: begin
        gen_keys = 1'b1;
        state_d  = ROUND1;
      end
      ROUND1: begin
        do_round1 = 1'b1;
        state_d   = ROUND2;
      end
      ROUND2: begin
        do_round2 = 1'b1;
        state_d   = FINAL;
      end
      FINAL: begin
        do_final = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath next values; strobes are mutually exclusive by construction.
  always_comb begin
    key_d  = key_q;
    ct_d   = ct_q;
    k1_d   = k1_q;
    k2_d   = k2_q;
    data_d = data_q;
    pt_d   = pt_q;
    done_d = do_final;
    if (latch_in) begin
      key_d = key;
      ct_d  = ct_in;
    end
    if (gen_keys) begin
      k1_d   = k1_sched;
      k2_d   = k2_sched;
      data_d = perm_ip(ct_q);
    end
    if (do_round1) begin
      data_d = {fk_out[3:0], fk_out[7:4]};
    end
    if (do_round2) begin
      data_d = fk_out;
    end
    if (do_final) begin
      pt_d = perm_ip_inv(data_q);
    end
  end

  // Datapath registers; reset wipes key material and any partial result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q  <= 10'd0;
      ct_q   <= 8'd0;
      k1_q   <= 8'd0;
      k2_q   <= 8'd0;
      data_q <= 8'd0;
      pt_q   <= 8'd0;
      done_q <= 1'b0;
    end else begin
      key_q  <= key_d;
      ct_q   <= ct_d;
      k1_q   <= k1_d;
      k2_q   <= k2_d;
      data_q <= data_d;
      pt_q   <= pt_d;
      done_q <= done_d;
    end
  end

  assign pt_out = pt_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sdes_decrypt.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdes_decrypt
// Purpose  : Self-checking bench for sdes_decrypt with a table-driven S-DES
//            reference model (generic permutation by position list).
// Revision : 1.0  initial release
// ============================================================================
module tb_sdes_decrypt;

  localparam logic [9:0] KV_KEY = 10'b1010000010;
  localparam logic [7:0] KV_CT  = 8'b00111000;
  localparam logic [7:0] KV_PT  = 8'b10010111;
  localparam logic [7:0] KV_K1  = 8'b10100100;
  localparam logic [7:0] KV_K2  = 8'b01000011;

  // Permutation position lists, one hex digit per output bit (A = 10).
  localparam logic [39:0] P10_T  = 40'h35274A1986;
  localparam logic [39:0] P8_T   = 40'h00637485A9;
  localparam logic [39:0] IP_T   = 40'h0026314857;
  localparam logic [39:0] IPI_T  = 40'h0041357286;
  localparam logic [39:0] EP_T   = 40'h0041232341;
  localparam logic [39:0] P4_T   = 40'h0000002431;

  int s0_tab [4][4] = '{'{1, 0, 3, 2}, '{3, 2, 1, 0}, '{0, 2, 1, 3}, '{3, 1, 3, 2}};
  int s1_tab [4][4] = '{'{0, 1, 2, 3}, '{2, 0, 1, 3}, '{3, 0, 1, 0}, '{2, 1, 0, 3}};

  logic       clk;
  logic       rst;
  logic       start;
  logic [9:0] key;
  logic [7:0] ct_in;
  logic [7:0] pt_out;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  sdes_decrypt dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .key    (key),
    .ct_in  (ct_in),
    .pt_out (pt_out),
    .busy   (busy),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  function automatic int unsigned perm(int unsigned val, int nin, int nout, logic [39:0] tbl);
    int unsigned r;
    int src;
    r = 0;
    for (int i = 1; i <= nout; i++) begin
      src = int'(tbl[4*(nout-i) +: 4]);
      if (((val >> (nin - src)) & 1) != 0) r = r | (32'd1 << (nout - i));
    end
    return r;
  endfunction

  function automatic int unsigned rotl5(int unsigned x, int n);
    return ((x << n) | (x >> (5 - n))) & 32'h1F;
  endfunction

  function automatic void model_keys(int unsigned k, output int unsigned k1, output int unsigned k2);
    int unsigned p, l, r;
    p  = perm(k, 10, 10, P10_T);
    l  = (p >> 5) & 31;
    r  = p & 31;
    k1 = perm((rotl5(l, 1) << 5) | rotl5(r, 1), 10, 8, P8_T);
    k2 = perm((rotl5(l, 3) << 5) | rotl5(r, 3), 10, 8, P8_T);
  endfunction

  function automatic int unsigned model_fk(int unsigned x, int unsigned k);
    int unsigned l, r, t, a, b, s0v, s1v, p;
    l   = (x >> 4) & 15;
    r   = x & 15;
    t   = perm(r, 4, 8, EP_T) ^ k;
    a   = (t >> 4) & 15;
    b   = t & 15;
    s0v = s0_tab[((a >> 3) & 1) * 2 + (a & 1)][((a >> 2) & 1) * 2 + ((a >> 1) & 1)];
    s1v = s1_tab[((b >> 3) & 1) * 2 + (b & 1)][((b >> 2) & 1) * 2 + ((b >> 1) & 1)];
    p   = perm((s0v << 2) | s1v, 4, 4, P4_T);
    return ((l ^ p) << 4) | r;
  endfunction

  function automatic int unsigned swap_nib(int unsigned x);
    return ((x & 15) << 4) | ((x >> 4) & 15);
  endfunction

  function automatic int unsigned model_encrypt(int unsigned k, int unsigned pt);
    int unsigned k1, k2, y;
    model_keys(k, k1, k2);
    y = perm(pt, 8, 8, IP_T);
    y = swap_nib(model_fk(y, k1));
    y = model_fk(y, k2);
    return perm(y, 8, 8, IPI_T);
  endfunction

  function automatic int unsigned model_decrypt(int unsigned k, int unsigned ct);
    int unsigned k1, k2, y;
    model_keys(k, k1, k2);
    y = perm(ct, 8, 8, IP_T);
    y = swap_nib(model_fk(y, k2));
    y = model_fk(y, k1);
    return perm(y, 8, 8, IPI_T);
  endfunction

  // One request; returns in the done cycle (#1 after the completing edge).
  // lat = edges from the sampling edge to done, or -1 on timeout.
  task automatic run_op(input logic [9:0] k, input logic [7:0] c, input bit scramble,
                        output logic [7:0] pt, output int lat);
    int n;
    key   = k;
    ct_in = c;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (scramble) begin
      key   = 10'd0;
      ct_in = 8'd0;
    end
    n   = 0;
    lat = -1;
    while (n < 10 && lat < 0) begin
      @(posedge clk); #1;
      n++;
      if (done === 1'b1) lat = n;
    end
    pt = pt_out;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset;
    rst = 1'b1; start = 1'b0; key = '0; ct_in = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (pt_out !== 8'h00) begin failures++; $display("FAIL reset_pt: got %h expected 00", pt_out); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b expected 0", done); end
    rst = 1'b0;
  endtask

  // Known vector immediately after reset release, with cycle-by-cycle checks.
  task automatic test_known_vector;
    int unsigned exp;
    exp = model_decrypt(KV_KEY, KV_CT);
    checks++; if (exp[7:0] !== KV_PT) begin failures++; $display("FAIL model_kv: got %h expected %h", exp[7:0], KV_PT); end
    key = KV_KEY; ct_in = KV_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL kv_cycle0: busy=%b done=%b expected busy=1 done=0", busy, done); end
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        checks++; if (dut.k1_q !== KV_K1) begin failures++; $display("FAIL kv_k1: got %b expected %b", dut.k1_q, KV_K1); end
        checks++; if (dut.k2_q !== KV_K2) begin failures++; $display("FAIL kv_k2: got %b expected %b", dut.k2_q, KV_K2); end
      end
      if (i < 4) begin
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL kv_cycle%0d: busy=%b done=%b expected busy=1 done=0", i, busy, done); end
      end else begin
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL kv_done: busy=%b done=%b expected busy=0 done=1", busy, done); end
        checks++; if (pt_out !== KV_PT) begin failures++; $display("FAIL kv_pt: got %b expected %b", pt_out, KV_PT); end
      end
    end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL kv_done_width: got %b expected 0", done); end
    checks++; if (pt_out !== KV_PT) begin failures++; $display("FAIL kv_pt_hold: got %b expected %b", pt_out, KV_PT); end
  endtask

  task automatic test_input_stability;
    logic [7:0] pt;
    int lat;
    run_op(KV_KEY, KV_CT, 1'b1, pt, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL stab_latency: got %0d expected 4", lat); end
    checks++; if (pt !== KV_PT) begin failures++; $display("FAIL stab_pt: got %b expected %b", pt, KV_PT); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] pt;
    int lat;
    run_op(KV_KEY, KV_CT, 1'b0, pt, lat);
    checks++; if (lat !== 4 || pt !== KV_PT) begin failures++; $display("FAIL b2b_first: lat=%0d pt=%h expected lat=4 pt=%h", lat, pt, KV_PT); end
    // second start issued in the done cycle
    run_op(KV_KEY, KV_CT, 1'b0, pt, lat);
    checks++; if (lat !== 4) begin failures++; $display("FAIL b2b_latency: got %0d expected 4", lat); end
    checks++; if (pt !== KV_PT) begin failures++; $display("FAIL b2b_pt: got %h expected %h", pt, KV_PT); end
  endtask

  task automatic test_busy_ignore;
    int ndone, first;
    logic [7:0] pt_at_done;
    ndone = 0; first = -1; pt_at_done = '0;
    key = KV_KEY; ct_in = KV_CT; start = 1'b1;
    @(posedge clk); #1;
    key   = 10'($urandom);
    ct_in = 8'($urandom);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk); #1;
      if (n == 2) start = 1'b0;
      if (done === 1'b1) begin
        ndone++;
        if (first < 0) begin first = n; pt_at_done = pt_out; end
      end
    end
    checks++; if (ndone !== 1) begin failures++; $display("FAIL ignore_count: got %0d done pulses expected 1", ndone); end
    checks++; if (first !== 4) begin failures++; $display("FAIL ignore_latency: got %0d expected 4", first); end
    checks++; if (pt_at_done !== KV_PT) begin failures++; $display("FAIL ignore_pt: got %h expected %h", pt_at_done, KV_PT); end
  endtask

  task automatic test_reset_mid;
    int bad_done, bad_pt, lat;
    bad_done = 0; bad_pt = 0;
    key = KV_KEY; ct_in = KV_CT; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL rstmid_done: got %b expected 0", done); end
    checks++; if (pt_out !== 8'h00) begin failures++; $display("FAIL rstmid_pt: got %h expected 00", pt_out); end
    #2;
    rst = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk); #1;
      if (done !== 1'b0) bad_done++;
      if (pt_out !== 8'h00) bad_pt++;
    end
    checks++; if (bad_done !== 0) begin failures++; $display("FAIL rstmid_nodone: got %0d done cycles expected 0", bad_done); end
    checks++; if (bad_pt !== 0) begin failures++; $display("FAIL rstmid_pt_hold: got %0d nonzero cycles expected 0", bad_pt); end
    // start held across reset release: must be taken at the first edge
    #3;
    rst = 1'b1;
    key = KV_KEY; ct_in = KV_CT; start = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 10 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (done === 1'b1) lat = n;
    end
    checks++; if (lat !== 4) begin failures++; $display("FAIL rstmid_restart_latency: got %0d expected 4", lat); end
    checks++; if (pt_out !== KV_PT) begin failures++; $display("FAIL rstmid_restart_pt: got %h expected %h", pt_out, KV_PT); end
  endtask

  task automatic test_random;
    logic [9:0] k;
    logic [7:0] c, pt;
    int unsigned exp;
    int lat;
    for (int i = 0; i < 40; i++) begin
      k   = 10'($urandom);
      c   = 8'($urandom);
      exp = model_decrypt(k, c);
      run_op(k, c, ($urandom_range(0, 1) == 1), pt, lat);
      checks++; if (lat !== 4 || pt !== exp[7:0]) begin failures++; $display("FAIL random key=%h ct=%h: lat=%0d pt=%h expected lat=4 pt=%h", k, c, lat, pt, exp[7:0]); end
    end
  endtask

  task automatic test_round_trip;
    logic [7:0] pt;
    int unsigned ct;
    int lat;
    for (int p = 0; p < 256; p++) begin
      ct = model_encrypt(KV_KEY, p);
      run_op(KV_KEY, ct[7:0], 1'b0, pt, lat);
      checks++; if (lat !== 4 || pt !== 8'(p)) begin failures++; $display("FAIL roundtrip p=%h ct=%h: lat=%0d pt=%h expected lat=4 pt=%h", p[7:0], ct[7:0], lat, pt, p[7:0]); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset;
    test_known_vector;
    test_input_stability;
    test_back_to_back;
    test_busy_ignore;
    test_reset_mid;
    test_random;
    test_round_trip;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
